// File: rtl/tdc_hist_pkg.sv
// Shared types and defaults for the TDC code-density histogram.
package tdc_hist_pkg;

    // Default widths: fine code, per-bin counter, total/drop counters.
    localparam int unsigned DefCodeW = 8;
    localparam int unsigned DefCntW  = 16;
    localparam int unsigned DefTotW  = 32;

    // Cycles spent in DRAIN so in-flight read-modify-writes retire.
    localparam int unsigned DRAIN_CYC = 2;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StAccum,
        StDrain,
        StReadout
    } hist_state_e;

endpackage

// File: rtl/tdc_hist_ram.sv
// Simple dual-port bin memory: one write port, one registered read port.
module tdc_hist_ram
    import tdc_hist_pkg::*;
#(
    parameter int unsigned AddrW = DefCodeW,
    parameter int unsigned DataW = DefCntW
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [DataW-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [DataW-1:0] rdata_o
);

    logic [DataW-1:0] mem_q [1 << AddrW];
    logic [DataW-1:0] rdata_q;

    // Write-then-read in one edge returns the old word (read-before-write).
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tdc_code_hist.sv
// Code-density histogram: saturating per-code bins in RAM, streamed out on valid/ready.
module tdc_code_hist
    import tdc_hist_pkg::*;
#(
    parameter int unsigned CODE_W = DefCodeW,
    parameter int unsigned CNT_W  = DefCntW,
    parameter int unsigned TOT_W  = DefTotW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hit_valid,
    input  logic [CODE_W-1:0] hit_code,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              cmd_readout,
    input  logic              cmd_clear,
    input  logic              clr_on_read,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [CODE_W-1:0] rd_bin,
    output logic [CNT_W-1:0]  rd_count,
    output logic              rd_last,
    output logic [TOT_W-1:0]  total_hits,
    output logic [TOT_W-1:0]  drop_cnt,
    output logic              busy
);

    localparam logic [CODE_W-1:0] LastBin = {CODE_W{1'b1}};
    localparam logic [CNT_W-1:0]  CntMax  = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0]  TotMax  = {TOT_W{1'b1}};
    localparam int unsigned       DrainW  = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYC - 1);

    hist_state_e       state_q, state_d;
    logic [CODE_W-1:0] clr_idx_q, clr_idx_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              clr_pend_q, clr_pend_d;
    logic              enter_clear, start_rd;

    logic [TOT_W-1:0]  total_q, total_d;
    logic [TOT_W-1:0]  drop_q, drop_d;

    // Increment pipeline: S1 has RAM data, S2 writes, S3 remembers last write.
    logic              s1_vld_q, s2_vld_q, s3_vld_q;
    logic [CODE_W-1:0] s1_code_q, s2_code_q, s3_code_q;
    logic [CNT_W-1:0]  s2_val_q, s3_val_q;
    logic [CNT_W-1:0]  s1_base, s1_new;
    logic              hit_acc, hit_drop;

    // Readout: fetch address, one read in flight, prefetch slot, output beat.
    logic [CODE_W:0]   fetch_addr_q, fetch_addr_d;
    logic              fl_vld_q, fl_vld_d;
    logic [CODE_W-1:0] fl_bin_q, fl_bin_d;
    logic              pf_vld_q, pf_vld_d;
    logic [CODE_W-1:0] pf_bin_q, pf_bin_d;
    logic [CNT_W-1:0]  pf_cnt_q, pf_cnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [CODE_W-1:0] rd_bin_q, rd_bin_d;
    logic [CNT_W-1:0]  rd_count_q, rd_count_d;
    logic              rd_last_q, rd_last_d;
    logic              pop, rd_issue;
    logic [1:0]        occ;

    logic              ram_we;
    logic [CODE_W-1:0] ram_waddr, ram_raddr;
    logic [CNT_W-1:0]  ram_wdata, ram_rdata;

    assign hit_acc  = hit_valid && (state_q == StAccum);
    assign hit_drop = hit_valid && (state_q inside {StIdle, StReadout, StClear});
    assign pop      = rd_valid_q && rd_ready;
    assign occ      = {1'b0, rd_valid_q} + {1'b0, pf_vld_q} + {1'b0, fl_vld_q};
    // Only fetch when the data landing next cycle is guaranteed a free slot.
    assign rd_issue = (state_q == StReadout) && !fetch_addr_q[CODE_W]
                      && ((occ < 2'd2) || (pop && (occ == 2'd2)));

    // FSM next state; IDLE priority is clear > readout > start.
    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        drain_d     = drain_q;
        clr_pend_d  = clr_pend_q;
        enter_clear = 1'b0;
        start_rd    = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LastBin) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (cmd_clear) begin
                    state_d     = StClear;
                    enter_clear = 1'b1;
                end else if (cmd_readout) begin
                    state_d    = StReadout;
                    start_rd   = 1'b1;
                    clr_pend_d = clr_on_read;
                end else if (cmd_start) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (cmd_stop) begin
                    state_d = StDrain;
                    drain_d = '0;
                end
            end
            StDrain: begin
                if (drain_q == DrainLast) begin
                    state_d = StIdle;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StReadout: begin
                if (pop && rd_last_q) begin
                    if (clr_pend_q) begin
                        state_d     = StClear;
                        enter_clear = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StClear;
        endcase
        if (enter_clear) begin
            clr_idx_d = '0;
        end
    end

    // Saturating totals; entering CLEAR overrides any same-cycle increment.
    always_comb begin
        total_d = total_q;
        drop_d  = drop_q;
        if (hit_acc && (total_q != TotMax)) begin
            total_d = total_q + 1'b1;
        end
        if (hit_drop && (drop_q != TotMax)) begin
            drop_d = drop_q + 1'b1;
        end
        if (enter_clear) begin
            total_d = '0;
            drop_d  = '0;
        end
    end

    // S1 increment: the two younger writes may not be in the RAM word yet.
    always_comb begin
        s1_base = ram_rdata;
        if (s2_vld_q && (s2_code_q == s1_code_q)) begin
            s1_base = s2_val_q;
        end else if (s3_vld_q && (s3_code_q == s1_code_q)) begin
            s1_base = s3_val_q;
        end
        s1_new = (s1_base == CntMax) ? s1_base : s1_base + 1'b1;
    end

    // Readout fetch and prefetch/output staging.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        fl_vld_d     = 1'b0;
        fl_bin_d     = fl_bin_q;
        if (start_rd) begin
            fetch_addr_d = {{CODE_W{1'b0}}, 1'b1};
            fl_vld_d     = 1'b1;
            fl_bin_d     = '0;
        end else if (rd_issue) begin
            fetch_addr_d = fetch_addr_q + 1'b1;
            fl_vld_d     = 1'b1;
            fl_bin_d     = fetch_addr_q[CODE_W-1:0];
        end

        rd_valid_d = rd_valid_q;
        rd_bin_d   = rd_bin_q;
        rd_count_d = rd_count_q;
        pf_vld_d   = pf_vld_q;
        pf_bin_d   = pf_bin_q;
        pf_cnt_d   = pf_cnt_q;
        if (!rd_valid_q || pop) begin
            if (pf_vld_q) begin
                rd_valid_d = 1'b1;
                rd_bin_d   = pf_bin_q;
                rd_count_d = pf_cnt_q;
                pf_vld_d   = fl_vld_q;
                pf_bin_d   = fl_bin_q;
                pf_cnt_d   = ram_rdata;
            end else if (fl_vld_q) begin
                rd_valid_d = 1'b1;
                rd_bin_d   = fl_bin_q;
                rd_count_d = ram_rdata;
            end else begin
                rd_valid_d = 1'b0;
            end
        end else if (fl_vld_q) begin
            pf_vld_d = 1'b1;
            pf_bin_d = fl_bin_q;
            pf_cnt_d = ram_rdata;
        end
        rd_last_d = rd_valid_d && (rd_bin_d == LastBin);
    end

    // RAM port arbitration: CLEAR owns the write port, READOUT the read port.
    always_comb begin
        ram_we    = (state_q == StClear) || s2_vld_q;
        ram_waddr = (state_q == StClear) ? clr_idx_q : s2_code_q;
        ram_wdata = (state_q == StClear) ? '0 : s2_val_q;
        if (state_q == StAccum) begin
            ram_raddr = hit_code;
        end else if (start_rd) begin
            ram_raddr = '0;
        end else begin
            ram_raddr = fetch_addr_q[CODE_W-1:0];
        end
    end

    // All state; reset aborts any operation and restarts the clear walk.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StClear;
            clr_idx_q    <= '0;
            drain_q      <= '0;
            clr_pend_q   <= 1'b0;
            total_q      <= '0;
            drop_q       <= '0;
            s1_vld_q     <= 1'b0;
            s1_code_q    <= '0;
            s2_vld_q     <= 1'b0;
            s2_code_q    <= '0;
            s2_val_q     <= '0;
            s3_vld_q     <= 1'b0;
            s3_code_q    <= '0;
            s3_val_q     <= '0;
            fetch_addr_q <= '0;
            fl_vld_q     <= 1'b0;
            fl_bin_q     <= '0;
            pf_vld_q     <= 1'b0;
            pf_bin_q     <= '0;
            pf_cnt_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_bin_q     <= '0;
            rd_count_q   <= '0;
            rd_last_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            drain_q      <= drain_d;
            clr_pend_q   <= clr_pend_d;
            total_q      <= total_d;
            drop_q       <= drop_d;
            s1_vld_q     <= hit_acc;
            s1_code_q    <= hit_code;
            s2_vld_q     <= s1_vld_q;
            s2_code_q    <= s1_code_q;
            s2_val_q     <= s1_new;
            s3_vld_q     <= s2_vld_q;
            s3_code_q    <= s2_code_q;
            s3_val_q     <= s2_val_q;
            fetch_addr_q <= fetch_addr_d;
            fl_vld_q     <= fl_vld_d;
            fl_bin_q     <= fl_bin_d;
            pf_vld_q     <= pf_vld_d;
            pf_bin_q     <= pf_bin_d;
            pf_cnt_q     <= pf_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_bin_q     <= rd_bin_d;
            rd_count_q   <= rd_count_d;
            rd_last_q    <= rd_last_d;
        end
    end

    tdc_hist_ram #(
        .AddrW (CODE_W),
        .DataW (CNT_W)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    assign rd_valid   = rd_valid_q;
    assign rd_bin     = rd_bin_q;
    assign rd_count   = rd_count_q;
    assign rd_last    = rd_last_q;
    assign total_hits = total_q;
    assign drop_cnt   = drop_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_tdc_code_hist.sv
// Bench for tdc_code_hist: two instances (16-bit and 4-bit bins) share all stimulus.
module tb_tdc_code_hist;

    localparam int NB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, hit_valid, cmd_start, cmd_stop, cmd_readout, cmd_clear, clr_on_read;
    logic       rd_ready;
    logic [7:0] hit_code;

    logic        a_valid, a_last, a_busy, b_valid, b_last, b_busy;
    logic [7:0]  a_bin, b_bin;
    logic [15:0] a_cnt;
    logic [3:0]  b_cnt;
    logic [31:0] a_tot, a_drop, b_tot, b_drop;

    tdc_code_hist #(.CODE_W(8), .CNT_W(16), .TOT_W(32)) u_dut_a (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_code(hit_code),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_readout(cmd_readout),
        .cmd_clear(cmd_clear), .clr_on_read(clr_on_read), .rd_valid(a_valid),
        .rd_ready(rd_ready), .rd_bin(a_bin), .rd_count(a_cnt), .rd_last(a_last),
        .total_hits(a_tot), .drop_cnt(a_drop), .busy(a_busy)
    );

    tdc_code_hist #(.CODE_W(8), .CNT_W(4), .TOT_W(32)) u_dut_b (
        .clk(clk), .rst(rst), .hit_valid(hit_valid), .hit_code(hit_code),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_readout(cmd_readout),
        .cmd_clear(cmd_clear), .clr_on_read(clr_on_read), .rd_valid(b_valid),
        .rd_ready(rd_ready), .rd_bin(b_bin), .rd_count(b_cnt), .rd_last(b_last),
        .total_hits(b_tot), .drop_cnt(b_drop), .busy(b_busy)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: unbounded true counts; each DUT's view is clamped to its width.
    int unsigned mbin [NB];
    int unsigned mtotal, mdrop;
    int unsigned cap_a [NB];
    int unsigned cap_b [NB];
    int          hitq [$];

    typedef struct {
        int code;
        int n;
        int exp_a;
        int exp_b;
    } vec_t;
    vec_t vecs [4];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v, input int unsigned m);
        return (v > m) ? m : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        foreach (mbin[i]) mbin[i] = 0;
        mtotal = 0;
        mdrop  = 0;
    endtask

    task automatic chk_totals(input string tag);
        chk({tag, " total_a"}, a_tot, mtotal);
        chk({tag, " total_b"}, b_tot, mtotal);
        chk({tag, " drop_a"}, a_drop, mdrop);
        chk({tag, " drop_b"}, b_drop, mdrop);
    endtask

    task automatic chk_busy(input string tag, input bit exp);
        chk({tag, " busy_a"}, a_busy, exp);
        chk({tag, " busy_b"}, b_busy, exp);
    endtask

    // Caller is in clear cycle 0; IDLE must appear exactly NB cycles in.
    task automatic wait_clear(input string tag);
        repeat (NB - 1) tick();
        chk_busy({tag, " last clear cycle"}, 1'b1);
        tick();
        chk_busy({tag, " idle after clear"}, 1'b0);
    endtask

    task automatic do_clear(input bit with_start);
        cmd_clear = 1'b1;
        cmd_start = with_start;
        tick();
        cmd_clear = 1'b0;
        cmd_start = 1'b0;
        model_clear();
        chk_busy("clear entry", 1'b1);
        chk_totals("clear entry");
        wait_clear("clear");
    endtask

    // Runs one ACCUM session over hitq; the last hit shares its cycle with cmd_stop.
    task automatic do_accum(input bit gaps);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        chk_busy("accum", 1'b1);
        if (hitq.size() == 0) begin
            cmd_stop = 1'b1;
            tick();
            cmd_stop = 1'b0;
        end
        for (int i = 0; i < hitq.size(); i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) tick();
            end
            hit_valid = 1'b1;
            hit_code  = 8'(hitq[i]);
            cmd_stop  = (i == hitq.size() - 1);
            mbin[hitq[i]]++;
            mtotal++;
            tick();
            hit_valid = 1'b0;
            cmd_stop  = 1'b0;
            chk("total_hits next cycle", a_tot, mtotal);
        end
        chk_totals("after stop");
        chk_busy("drain 0", 1'b1);
        tick();
        chk_busy("drain 1", 1'b1);
        tick();
        chk_busy("idle after drain", 1'b0);
        hitq.delete();
    endtask

    task automatic do_readout(input bit clr, input bit rnd_ready, input bit drop_hits);
        int   idx;
        int   budget;
        bit   done;
        bit   stall;
        logic [7:0]  p_bin;
        logic [15:0] p_cnt_a;
        logic [3:0]  p_cnt_b;
        logic        p_last;
        cmd_readout = 1'b1;
        clr_on_read = clr;
        tick();
        cmd_readout = 1'b0;
        clr_on_read = 1'b0;
        chk("rd_valid one cycle after cmd", a_valid, 0);
        tick();
        chk("rd_valid_a two cycles after cmd", a_valid, 1);
        chk("rd_valid_b two cycles after cmd", b_valid, 1);
        idx = 0; budget = 0; done = 1'b0; stall = 1'b0;
        p_bin = '0; p_cnt_a = '0; p_cnt_b = '0; p_last = 1'b0;
        while (!done) begin
            if (stall) begin
                chk("stall rd_valid", a_valid, 1);
                chk("stall rd_bin", a_bin, p_bin);
                chk("stall rd_count_a", a_cnt, p_cnt_a);
                chk("stall rd_count_b", b_cnt, p_cnt_b);
                chk("stall rd_last", a_last, p_last);
            end
            rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (drop_hits) begin
                hit_valid = ($urandom_range(0, 3) == 0);
                hit_code  = 8'($urandom);
                if (hit_valid) mdrop++;
            end
            if (a_valid && rd_ready) begin
                chk("beat bin_a", a_bin, idx);
                chk("beat bin_b", b_bin, idx);
                chk("beat count_a", a_cnt, sat(mbin[idx], 65535));
                chk("beat count_b", b_cnt, sat(mbin[idx], 15));
                chk("beat last_a", a_last, (idx == NB - 1));
                chk("beat last_b", b_last, (idx == NB - 1));
                cap_a[idx] = a_cnt;
                cap_b[idx] = b_cnt;
                if (idx == NB - 1) done = 1'b1;
                idx++;
            end
            stall   = a_valid && !rd_ready;
            p_bin   = a_bin;
            p_cnt_a = a_cnt;
            p_cnt_b = b_cnt;
            p_last  = a_last;
            tick();
            budget++;
            if (!done && budget > 4000) begin
                chk("readout beats before timeout", idx, NB);
                done = 1'b1;
            end
        end
        hit_valid = 1'b0;
        rd_ready  = 1'b0;
        chk("rd_valid after last beat", a_valid, 0);
        if (clr) begin
            model_clear();
            chk_busy("clear-on-read entry", 1'b1);
            chk_totals("clear-on-read entry");
            wait_clear("clear-on-read");
        end else begin
            chk_busy("idle after readout", 1'b0);
            chk_totals("after readout");
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; hit_valid = 1'b0; hit_code = '0; cmd_start = 1'b0; cmd_stop = 1'b0;
        cmd_readout = 1'b0; cmd_clear = 1'b0; clr_on_read = 1'b0; rd_ready = 1'b0;
        vecs[0] = '{8'h37, 10, 10, 10};
        vecs[1] = '{8'h00, 20, 20, 15};
        vecs[2] = '{8'hff, 1, 1, 1};
        vecs[3] = '{8'h80, 17, 17, 15};

        // Reset values, then the clear walk to IDLE.
        repeat (3) tick();
        chk("reset rd_valid", a_valid, 0);
        chk("reset rd_last", a_last, 0);
        chk("reset rd_bin", a_bin, 0);
        chk("reset rd_count_a", a_cnt, 0);
        chk("reset rd_count_b", b_cnt, 0);
        model_clear();
        chk_totals("reset");
        chk_busy("reset", 1'b1);
        rst = 1'b0;
        wait_clear("post-reset");
        do_readout(1'b0, 1'b0, 1'b0);

        // Drops in IDLE, then clear beats start in the same cycle.
        for (int i = 0; i < 4; i++) begin
            hit_valid = 1'b1;
            hit_code  = 8'($urandom);
            mdrop++;
            tick();
        end
        hit_valid = 1'b0;
        chk("idle drops", a_drop, 4);
        chk_totals("idle drops");
        do_clear(1'b1);

        // Reset in the middle of accumulation aborts and re-clears.
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        hit_valid = 1'b1;
        hit_code  = 8'd9;
        tick();
        tick();
        hit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk_totals("mid-op reset");
        chk_busy("mid-op reset", 1'b1);
        wait_clear("mid-op reset");

        // Table: back-to-back hits on one bin, with and without saturation.
        for (int v = 0; v < 4; v++) begin
            do_clear(1'b0);
            for (int k = 0; k < vecs[v].n; k++) hitq.push_back(vecs[v].code);
            do_accum(1'b0);
            chk("table total_hits", a_tot, vecs[v].n);
            do_readout(1'b0, 1'b0, 1'b0);
            chk("table bin_a", cap_a[vecs[v].code], vecs[v].exp_a);
            chk("table bin_b", cap_b[vecs[v].code], vecs[v].exp_b);
        end

        // Alternating bins, then clear-on-read under backpressure and a zero readout.
        do_clear(1'b0);
        hitq = '{5, 6, 5, 6, 5};
        do_accum(1'b0);
        do_readout(1'b1, 1'b1, 1'b0);
        chk("alt bin5", cap_a[5], 3);
        chk("alt bin6", cap_a[6], 2);
        do_readout(1'b0, 1'b1, 1'b0);
        chk("zero after clear-on-read", cap_a[5], 0);

        // Random bursts on a narrow code window; start on the first IDLE after DRAIN.
        for (int r = 0; r < 4; r++) begin
            for (int b = 0; b < 2; b++) begin
                int base;
                int n;
                base = $urandom_range(0, NB - 4);
                n    = $urandom_range(0, 40);
                for (int k = 0; k < n; k++) hitq.push_back(base + $urandom_range(0, 3));
                do_accum(r[0]);
            end
            do_readout(1'($urandom_range(0, 1)), 1'b1, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdc_code_hist.md
# tdc_code_hist

Code-density histogram for TDC fine-time calibration. Consumes the 8-bit binary fine code produced by the thermometer-to-binary stage (`out_bin`), qualified by a per-hit strobe derived from `filtered_hit`. It accumulates one saturating counter per code in block RAM and streams the finished histogram out over a valid/ready port for DNL/INL calibration. It sits directly downstream of the thermometer-to-binary stage, in the `clk118` domain.

## Interface
- `CODE_W`, 8: fine-code width; the histogram has 2^CODE_W bins.
- `CNT_W`, 16: per-bin counter width; counters saturate.
- `TOT_W`, 32: width of the total and dropped hit counters.

Ports:
- `clk`  in  1: single clock for all logic.
- `rst`  in  1: reset, synchronous and active-high.
- `hit_valid`  in  1: one-cycle strobe; `hit_code` is valid in the same cycle.
- `hit_code`  in  CODE_W: fine code from the thermometer-to-binary stage.
- `cmd_start`  in  1: pulse that begins accumulation.
- `cmd_stop`  in  1: pulse that ends accumulation.
- `cmd_readout`  in  1: pulse that starts the histogram stream.
- `cmd_clear`  in  1: pulse that zeroes all bins and both totals.
- `clr_on_read`  in  1: sampled with `cmd_readout`; when set, a clear runs after the stream completes.
- `rd_valid`  out  1: a histogram beat is presented.
- `rd_ready`  in  1: downstream accepts the beat.
- `rd_bin`  out  CODE_W: bin index of the current beat.
- `rd_count`  out  CNT_W: count for that bin.
- `rd_last`  out  1: asserted on the beat for bin 2^CODE_W-1.
- `total_hits`  out  TOT_W: number of hits accumulated.
- `drop_cnt`  out  TOT_W: number of hits that arrived outside ACCUM/DRAIN and were discarded.
- `busy`  out  1: high in every state except IDLE.

## Operation
States and transitions:
- CLEAR: walks bins 0..2^CODE_W-1, writing 0 at one bin per cycle, then goes to IDLE.
- IDLE accepts commands with priority clear > readout > start.
  - `cmd_clear` → CLEAR.
  - `cmd_readout` → READOUT.
  - `cmd_start` → ACCUM.
- ACCUM: each `hit_valid` increments `bin[hit_code]` and `total_hits`. `cmd_stop` → DRAIN.
- DRAIN: held for 2 cycles so the in-flight increments retire, then → IDLE.
- READOUT: streams bins 0..2^CODE_W-1 in order. After the `rd_last` handshake it goes to CLEAR if `clr_on_read` was latched, otherwise to IDLE.

Command rules:
- Commands arriving outside IDLE are ignored, except `cmd_stop` in ACCUM.
- `cmd_stop` arriving in the same cycle as a hit: that hit is counted.

Increment pipeline (read-modify-write):
- S0: issue the read address.
- S1: RAM data returns.
- S2: write the incremented value.
- Forwarding: when the S0 code equals the S1 or S2 code, use the in-flight value instead of stale RAM data. Back-to-back hits on one bin therefore count exactly.
- Saturation: a bin stops at 2^CNT_W-1. `total_hits` still increments, and it saturates at 2^TOT_W-1.

Drops:
- A hit in IDLE, READOUT or CLEAR increments `drop_cnt` (saturating) and leaves the RAM untouched.

Clearing:
- `total_hits` and `drop_cnt` are zeroed on entry to CLEAR.

## Timing
- Reset: `rst` has priority over every other input.
  - Outputs: `rd_valid`, `rd_last`, `rd_bin`, `rd_count`, `total_hits` and `drop_cnt` are 0.
  - `busy` is 1; the state is CLEAR.
  - IDLE is reached 2^CODE_W cycles after `rst` deasserts.
  - Reset in mid-operation aborts the operation and re-clears.
- Hit latency: a hit accepted at cycle t is visible in RAM at t+3.
- `total_hits` updates at t+1.
- `busy` falls in the cycle IDLE is entered.
- Readout:
  - `rd_valid` first rises 2 cycles after `cmd_readout`.
  - One beat is transferred per cycle while `rd_ready` is held high.
  - With `rd_ready` low, `rd_bin`, `rd_count` and `rd_last` hold stable. A 1-entry prefetch register covers the 1-cycle RAM read latency.
  - `rd_valid` never drops without a handshake.
- Beat ordering: `rd_bin` increments by exactly 1 per handshake, with no wrap and no repeat.
- Clear: takes exactly 2^CODE_W cycles.
- Start after stop: `cmd_start` on the first IDLE cycle after DRAIN is accepted.

## Structure
- Package `tdc_hist_pkg`: the state enum (CLEAR, IDLE, ACCUM, DRAIN, READOUT), default widths, and the `DRAIN_CYC = 2` constant.
- Sub-module `tdc_hist_ram`: simple dual-port synchronous RAM, 2^CODE_W × CNT_W, with a 1-cycle registered read, inferable as BSRAM.
  - Port arbitration: the ACCUM write port is shared with CLEAR; the read port is shared with READOUT.
- The top level holds the FSM, the forwarding/saturation logic, the counters and the readout prefetch.

## Test plan
- Reset cleared → IDLE:
  - Stimulus: assert `rst` for 3 cycles, release, wait 256 cycles.
  - Response: `busy`=0; readout yields 256 beats, all `rd_count`=0, `rd_last` only on bin 255.
- Back-to-back same bin:
  - Stimulus: in ACCUM, 10 consecutive hits with code 0x37, then `cmd_stop`.
  - Response: `bin[0x37]`=10, `total_hits`=10.
- Alternating bins:
  - Stimulus: codes 5, 6, 5, 6, 5 on consecutive cycles.
  - Response: `bin[5]`=3, `bin[6]`=2.
- Saturation:
  - Stimulus: CNT_W=4, then 20 hits to bin 0.
  - Response: `rd_count`=15, `total_hits`=20.
- Drops and command priority:
  - Stimulus: 4 hits in IDLE; then `cmd_clear` and `cmd_start` in the same cycle.
  - Response: `drop_cnt`=4 before the clear; CLEAR is entered, not ACCUM; afterwards `drop_cnt`=0 and `total_hits`=0.
- Backpressure and clear-on-read:
  - Stimulus: readout with `clr_on_read`=1 and random `rd_ready`.
  - Response: outputs stable while stalled; bins arrive in order 0..255; the FSM then runs 256 CLEAR cycles; a second readout returns all zeros.
